// File: rtl/quad_scan_sched.sv
// quad_scan_sched: Avalon-MM scan scheduler. It steps an external 4:1 sample
// mux, waits a settle time on each channel, captures it into a shadow
// register, then publishes all four shadows as one snapshot set in a single
// edge. Scans are started by a software trigger or by a periodic timer.
//
// Bus: a write is accepted on any clk edge with chipselect=1 and write_n=0
// (no wait states). readdata is registered every cycle from the addressed
// register regardless of chipselect, with one cycle of latency; reads have
// no side effects.
module quad_scan_sched #(
   parameter int          NUM_CH     = 4,
   parameter int          SETTLE     = 2,
   parameter logic [31:0] PERIOD_RST = 32'd1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [31:0] in_port,
   output logic [1:0]  ch_sel,
   output logic        scan_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SELECT  = 2'd1,
      CAPTURE = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [1:0] LAST_CH     = 2'(NUM_CH - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  ch;
   logic [3:0]  settle_cnt;
   logic [31:0] shadow [NUM_CH];
   logic [31:0] snap   [NUM_CH];
   logic [31:0] scan_cnt;
   logic [31:0] period;
   logic [31:0] timer;
   logic        enable;
   logic        overrun;
   logic        done;
   logic        busy;
   logic        commit;
   logic [31:0] rd_mux;

   logic wr;
   logic ctrl_wr;
   logic period_wr;
   logic sw_trig;
   logic clr_sticky;
   logic timer_trig;
   logic req;

   assign wr         = chipselect & ~write_n;
   assign ctrl_wr    = wr & (address == 3'd5);
   assign period_wr  = wr & (address == 3'd6);
   assign sw_trig    = ctrl_wr & writedata[1];
   assign clr_sticky = ctrl_wr & writedata[2];
   assign timer_trig = enable & (period != 32'd0) & (timer == 32'd0);
   // A software and a timer trigger in the same cycle merge into one request.
   assign req        = sw_trig | timer_trig;
   assign ch_sel     = ch;

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      commit    = 1'b0;
      scan_done = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (req) state_nxt = SELECT;
         end
         SELECT: begin
            if (settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            state_nxt = (ch == LAST_CH) ? COMMIT : SELECT;
         end
         COMMIT: begin
            commit    = 1'b1;
            scan_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Channel index and settle counter; ch stays on the last channel after a scan.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch         <= 2'd0;
         settle_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  ch         <= 2'd0;
                  settle_cnt <= 4'd0;
               end
            end
            SELECT:  settle_cnt <= settle_cnt + 4'd1;
            CAPTURE: begin
               if (ch != LAST_CH) begin
                  ch         <= ch + 2'd1;
                  settle_cnt <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Shadow capture of the currently selected channel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) shadow[i] <= 32'd0;
      end else if (state == CAPTURE) begin
         shadow[ch] <= in_port;
      end
   end

   // Snapshot set and scan count change only on the commit edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) snap[i] <= 32'd0;
         scan_cnt <= 32'd0;
      end else if (commit) begin
         for (int i = 0; i < NUM_CH; i++) snap[i] <= shadow[i];
         scan_cnt <= scan_cnt + 32'd1;
      end
   end

   // Sticky status bits; a set event beats a coincident clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
         done    <= 1'b0;
      end else begin
         if (req && busy)     overrun <= 1'b1;
         else if (clr_sticky) overrun <= 1'b0;
         if (commit)          done <= 1'b1;
         else if (clr_sticky) done <= 1'b0;
      end
   end

   // Control/period registers and the periodic down-counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable <= 1'b0;
         period <= PERIOD_RST;
         timer  <= PERIOD_RST - 32'd1;
      end else begin
         if (ctrl_wr)   enable <= writedata[0];
         if (period_wr) period <= writedata;
         if (period_wr)
            timer <= writedata - 32'd1;
         else if (ctrl_wr && writedata[0] && !enable)
            timer <= period - 32'd1;
         else if (!enable || (period == 32'd0) || (timer == 32'd0))
            timer <= period - 32'd1;
         else
            timer <= timer - 32'd1;
      end
   end

   // Read mux for the addressed register.
   always_comb begin
      rd_mux = 32'd0;
      case (address)
         3'd0, 3'd1, 3'd2, 3'd3: rd_mux = snap[address[1:0]];
         3'd4: rd_mux = {29'd0, done, overrun, busy};
         3'd5: rd_mux = {31'd0, enable};
         3'd6: rd_mux = period;
         3'd7: rd_mux = scan_cnt;
         default: rd_mux = 32'd0;
      endcase
   end

   // Registered read data, refreshed every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= 32'd0;
      else          readdata <= rd_mux;
   end

endmodule

// File: doc/quad_scan_sched.md
QUAD_SCAN_SCHED -- requirements
Module: quad_scan_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of multiplexed 32-bit sample channels (fixed 4; ch_sel 2 bits).
REQ-002 SHALL have parameter SETTLE, default 2, clk cycles ch_sel is held before capture (range 1..15).
REQ-003 SHALL have parameter PERIOD_RST, default 1000, reset value of the period register.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  input  1  system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 in_port  input  32  sample of the currently selected channel (external mux).
REQ-012 ch_sel  output  2  channel select driven to the external mux.
REQ-013 scan_done  output  1  one-cycle pulse when a scan commits.

Function
REQ-014 Register map SHALL be: 0-3 snapshot ch0-3 (RO); 4 status (RO: b0 busy, b1 overrun sticky, b2 done sticky); 5 control (b0 periodic enable RW, b1 sw trigger W1 self-clearing, b2 clear stickies W1 self-clearing); 6 period (RW, 32b); 7 scan count (RO, 32b).
REQ-015 readdata SHALL be registered every clk from the register addressed by address, regardless of chipselect: 1-cycle latency; reads SHALL have no side effects.
REQ-016 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; writes to RO addresses SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, SELECT, CAPTURE, COMMIT.
REQ-018 Timer: with enable=1 and period!=0, a down-counter loaded with period-1 SHALL raise a one-cycle trigger on reaching 0 and reload; with enable=0 or period=0 it SHALL hold at period-1 and not trigger.
REQ-019 Writing period or setting enable SHALL reload the timer with the new period-1.
REQ-020 sw trigger and timer trigger in the same cycle SHALL produce exactly one scan request.
REQ-021 IDLE + request -> SELECT with channel index 0, ch_sel=0, settle counter cleared.
REQ-022 SELECT SHALL hold ch_sel for SETTLE cycles, then -> CAPTURE.
REQ-023 CAPTURE SHALL latch in_port into shadow[ch] for one cycle; if ch<NUM_CH-1 -> SELECT with ch+1, else -> COMMIT.
REQ-024 COMMIT SHALL copy all four shadows into the snapshot registers in the same edge, increment scan count (wrap 0xFFFFFFFF->0), set done sticky, pulse scan_done, -> IDLE.
REQ-025 Snapshot registers SHALL change only in COMMIT, so software never reads a mixed-scan set.
REQ-026 A scan SHALL take NUM_CH*(SETTLE+1)+1 cycles from leaving IDLE to the COMMIT edge inclusive (13 at defaults).
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 A request while busy SHALL be dropped and set overrun sticky; the running scan SHALL continue unaffected.
REQ-029 A clear-stickies write coincident with a sticky-set event SHALL leave the sticky set (set wins).
REQ-030 ch_sel SHALL hold the last channel (3) after COMMIT and while IDLE.

Reset
REQ-031 On reset_n=0, asynchronously: FSM=IDLE, ch_sel=0, scan_done=0, readdata=0, snapshots/shadows=0, scan count=0, stickies=0, enable=0, period=PERIOD_RST, timer=PERIOD_RST-1.
REQ-032 Reset asserted mid-scan SHALL abort it without a commit; snapshots SHALL read 0 afterwards.

Verification
REQ-033 Mux model returns 0x1000_000N for ch_sel=N; sw trigger write -> busy for 13 cycles, ch_sel steps 0,1,2,3, scan_done once, addr 0-3 read 0x10000000..0x10000003, scan count=1.
REQ-034 period=20, enable=1 -> scan_done pulses exactly every 20 cycles; enable=0 -> no further pulses.
REQ-035 sw trigger issued 5 cycles into a scan -> single scan_done, overrun=1; clear write -> status b1=0.
REQ-036 Change mux model values during CAPTURE of ch2 and read snapshots each cycle -> old set until COMMIT edge, then full new set at once.
REQ-037 reset_n pulsed low in SELECT of ch1 -> all registers at reset values, scan_done never asserted, next sw trigger completes normally.
